// File: rtl/md5_ctrl_pkg.sv
// Shared constants for the MD5 search host controller: register map,
// FSM state codes, CTRL bit positions and bus widths.
package md5_ctrl_pkg;

    localparam int HASH_W = 128;
    localparam int DATA_W = 32;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_HASH0  = 4'd2;
    localparam logic [3:0] ADDR_HASH1  = 4'd3;
    localparam logic [3:0] ADDR_HASH2  = 4'd4;
    localparam logic [3:0] ADDR_HASH3  = 4'd5;
    localparam logic [3:0] ADDR_RESULT = 4'd6;
    localparam logic [3:0] ADDR_CYCLES = 4'd7;
    localparam logic [3:0] ADDR_IRQCLR = 4'd8;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SEARCH = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

endpackage

// File: rtl/md5_ctrl_regs.sv
// Host register file for the MD5 search controller: HASH words, irq enable,
// command strobes decoded from CTRL/IRQCLR writes, and the 1-cycle read port.
module md5_ctrl_regs
    import md5_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [3:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              reg_rvalid,
    input  logic              hash_wr_en,
    input  logic [DATA_W-1:0] status_word,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] cycles,
    output logic [HASH_W-1:0] hash,
    output logic              irq_en,
    output logic              start_cmd,
    output logic              abort_cmd,
    output logic              irqclr_cmd
);

    logic [DATA_W-1:0] hash_r [4];
    logic [DATA_W-1:0] rd_mux;
    logic              ctrl_wr;

    assign ctrl_wr    = reg_wr && (reg_addr == ADDR_CTRL);
    assign start_cmd  = ctrl_wr && reg_wdata[CTRL_START];
    assign abort_cmd  = ctrl_wr && reg_wdata[CTRL_ABORT];
    assign irqclr_cmd = reg_wr && (reg_addr == ADDR_IRQCLR);
    assign hash       = {hash_r[3], hash_r[2], hash_r[1], hash_r[0]};

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hash_r[i] <= '0;
            irq_en <= 1'b0;
        end else if (reg_wr) begin
            if (reg_addr == ADDR_CTRL) irq_en <= reg_wdata[CTRL_IRQ_EN];
            // Target hash is frozen while a search is in flight.
            if (hash_wr_en) begin
                case (reg_addr)
                    ADDR_HASH0: hash_r[0] <= reg_wdata;
                    ADDR_HASH1: hash_r[1] <= reg_wdata;
                    ADDR_HASH2: hash_r[2] <= reg_wdata;
                    ADDR_HASH3: hash_r[3] <= reg_wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_STATUS: rd_mux = status_word;
            ADDR_HASH0:  rd_mux = hash_r[0];
            ADDR_HASH1:  rd_mux = hash_r[1];
            ADDR_HASH2:  rd_mux = hash_r[2];
            ADDR_HASH3:  rd_mux = hash_r[3];
            ADDR_RESULT: rd_mux = result;
            ADDR_CYCLES: rd_mux = cycles;
            default:     rd_mux = '0;
        endcase
    end

    // Captured from pre-edge register values, so a same-cycle write reads old data.
    always_ff @(posedge CLK) begin
        if (reset) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd;
            reg_rdata  <= reg_rd ? rd_mux : '0;
        end
    end

endmodule

// File: rtl/md5_search_ctrl.sv
// Host-side controller for the MD5 brute-force driver: sequences enable and
// reset, latches result and elapsed cycles, and raises a completion interrupt.
module md5_search_ctrl
    import md5_ctrl_pkg::*;
#(
    parameter int PIPE_LAT     = 64,
    parameter int ABORT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [3:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              reg_rvalid,
    output logic [HASH_W-1:0] target_selected,
    output logic              enable_switch,
    output logic              drv_resetn,
    input  logic [DATA_W-1:0] target,
    input  logic              status_running,
    input  logic              status_warming,
    input  logic              status_found,
    input  logic              status_done,
    output logic              irq
);

    // Found flag trails the candidate by PIPE_LAT counter steps of 8 candidates each.
    localparam logic [DATA_W-1:0] RESULT_CORR = DATA_W'(PIPE_LAT << 3);
    localparam int ACW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    state_t            state, state_nxt;
    logic [ACW-1:0]    abort_cnt;
    logic [DATA_W-1:0] result, cycles, status_word;
    logic              done_latched, found_latched, aborted;
    logic              irq_en, start_cmd, abort_cmd, irqclr_cmd;
    logic              launch, search_done, drain_exit, abort_last, abort_enter;

    md5_ctrl_regs u_regs (
        .CLK         (CLK),
        .reset       (reset),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .hash_wr_en  (state == ST_IDLE),
        .status_word (status_word),
        .result      (result),
        .cycles      (cycles),
        .hash        (target_selected),
        .irq_en      (irq_en),
        .start_cmd   (start_cmd),
        .abort_cmd   (abort_cmd),
        .irqclr_cmd  (irqclr_cmd)
    );

    assign status_word = {24'd0, aborted, found_latched, done_latched,
                          status_running, status_warming, state};

    assign enable_switch = (state == ST_ARM) || (state == ST_SEARCH);
    assign drv_resetn    = (state != ST_ABORT);

    assign abort_last  = (state == ST_ABORT) && (abort_cnt == ACW'(ABORT_CYCLES - 1));
    assign launch      = (state == ST_IDLE) && start_cmd && !abort_cmd;
    assign search_done = (state == ST_SEARCH) && !abort_cmd && status_done;
    assign drain_exit  = (state == ST_DRAIN) && !abort_cmd && !status_done;
    assign abort_enter = (state_nxt == ST_ABORT) && (state != ST_ABORT);

    always_ff @(posedge CLK) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (launch) state_nxt = ST_ARM;
            ST_ARM:    if (abort_cmd) state_nxt = ST_ABORT;
                       else if (status_running) state_nxt = ST_SEARCH;
            ST_SEARCH: if (abort_cmd) state_nxt = ST_ABORT;
                       else if (status_done) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (abort_cmd) state_nxt = ST_ABORT;
                       else if (!status_done) state_nxt = ST_IDLE;
            ST_ABORT:  if (abort_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cycles        <= '0;
            result        <= '0;
            abort_cnt     <= '0;
            done_latched  <= 1'b0;
            found_latched <= 1'b0;
            aborted       <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (launch) begin
                cycles        <= '0;
                done_latched  <= 1'b0;
                found_latched <= 1'b0;
                aborted       <= 1'b0;
            end else if (enable_switch && (cycles != '1)) begin
                cycles <= cycles + DATA_W'(1);
            end

            if (search_done) begin
                found_latched <= status_found;
                result        <= status_found ? (target - RESULT_CORR) : target;
            end

            if (abort_enter)             abort_cnt <= '0;
            else if (state == ST_ABORT)  abort_cnt <= abort_cnt + ACW'(1);

            if (abort_last) aborted <= 1'b1;

            if (drain_exit)      done_latched <= 1'b1;
            else if (abort_last) done_latched <= 1'b0;
            else if (irqclr_cmd) done_latched <= 1'b0;

            // A completion in the same cycle as an IRQCLR write keeps irq set.
            if ((drain_exit || abort_last) && irq_en) irq <= 1'b1;
            else if (irqclr_cmd)                      irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Scoreboard bench for md5_search_ctrl with a behavioural MD5 driver model.
module tb_md5_search_ctrl;
    import md5_ctrl_pkg::*;

    localparam int PIPE_LAT     = 64;
    localparam int ABORT_CYCLES = 2;

    logic         CLK = 1'b0;
    logic         reset;
    logic         reg_wr, reg_rd;
    logic [3:0]   reg_addr;
    logic [31:0]  reg_wdata;
    logic [31:0]  reg_rdata;
    logic         reg_rvalid;
    logic [127:0] target_selected;
    logic         enable_switch, drv_resetn, irq;

    logic [31:0]  drv_target = '0;
    logic         drv_running = 1'b0, drv_warming = 1'b0, drv_found = 1'b0, drv_done = 1'b0;
    int           en_cnt = 0;
    int           cfg_done_at = 1000;
    logic         cfg_found = 1'b0;
    logic [31:0]  cfg_target = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        int          tol;
        int          issued;
        string       name;
    } rd_item_t;
    rd_item_t exp_q[$];

    logic [31:0] hash_m [4];
    logic        irq_m;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    md5_search_ctrl #(.PIPE_LAT(PIPE_LAT), .ABORT_CYCLES(ABORT_CYCLES)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .reg_wr          (reg_wr),
        .reg_rd          (reg_rd),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_rvalid      (reg_rvalid),
        .target_selected (target_selected),
        .enable_switch   (enable_switch),
        .drv_resetn      (drv_resetn),
        .target          (drv_target),
        .status_running  (drv_running),
        .status_warming  (drv_warming),
        .status_found    (drv_found),
        .status_done     (drv_done),
        .irq             (irq)
    );

    // Driver model: warms for 5 enabled cycles, runs, then reports done at cfg_done_at.
    always @(posedge CLK) begin
        if (reset || !drv_resetn) begin
            drv_running <= 1'b0;
            drv_warming <= 1'b0;
            drv_done    <= 1'b0;
            drv_found   <= 1'b0;
            en_cnt      <= 0;
        end else if (enable_switch) begin
            en_cnt      <= en_cnt + 1;
            drv_warming <= (en_cnt < 4);
            if (en_cnt == 4) drv_running <= 1'b1;
            if (en_cnt == cfg_done_at - 1) begin
                drv_done    <= 1'b1;
                drv_found   <= cfg_found;
                drv_target  <= cfg_target;
                drv_running <= 1'b0;
            end
        end else begin
            en_cnt      <= 0;
            drv_done    <= 1'b0;
            drv_running <= 1'b0;
            drv_warming <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        rd_item_t it;
        int diff;
        forever begin
            @(negedge CLK);
            if (reg_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rvalid", 1'b1, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    check({it.name, "_latency"}, 128'(cyc - it.issued), 128'd1);
                    if (it.tol > 0) begin
                        diff = int'(reg_rdata) - int'(it.exp);
                        if (diff < 0) diff = -diff;
                        checks++;
                        if (diff > it.tol) begin
                            errors++;
                            $display("FAIL %s: got %0h, expected %0h +/- %0d", it.name, reg_rdata, it.exp, it.tol);
                        end
                    end else begin
                        check(it.name, reg_rdata & it.mask, it.exp & it.mask);
                    end
                end
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge CLK);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input logic [31:0] m,
                      input int tol, input string name);
        rd_item_t it;
        @(negedge CLK);
        it.exp = e; it.mask = m; it.tol = tol; it.issued = cyc; it.name = name;
        exp_q.push_back(it);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge CLK);
        reg_rd = 1'b0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] old);
        rd_item_t it;
        @(negedge CLK);
        it.exp = old; it.mask = '1; it.tol = 0; it.issued = cyc; it.name = "rd_during_wr";
        exp_q.push_back(it);
        reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge CLK);
        reg_rd = 1'b0; reg_wr = 1'b0;
    endtask

    task automatic start_search(input int done_at, input logic found, input logic [31:0] tgt,
                                input logic ien);
        int n;
        cfg_done_at = done_at; cfg_found = found; cfg_target = tgt;
        wr(ADDR_CTRL, {29'd0, ien, 2'b01});
        n = 0;
        while (!drv_running && n < 20) begin @(negedge CLK); n++; end
        check("running_seen", drv_running, 1'b1);
        @(negedge CLK);
    endtask

    task automatic finish_search(input int done_at, input logic found, input logic [31:0] tgt,
                                 input logic ien);
        int n;
        logic [31:0] exp_res;
        exp_res = found ? (tgt - 32'(PIPE_LAT * 8)) : tgt;
        n = 0;
        while (!drv_done && n < done_at + 20) begin @(negedge CLK); n++; end
        check("done_seen", drv_done, 1'b1);
        check("enable_at_done", enable_switch, 1'b1);
        @(negedge CLK);
        check("enable_drop", enable_switch, 1'b0);
        repeat (4) @(negedge CLK);
        irq_m = irq_m | ien;
        check("irq_after_done", irq, irq_m);
        rd(ADDR_STATUS, {24'd0, 1'b0, found, 1'b1, 5'd0}, 32'hFF, 0, "status_done");
        rd(ADDR_RESULT, exp_res, '1, 0, "result");
        rd(ADDR_CYCLES, 32'(done_at), '1, 1, "cycles");
    endtask

    initial begin
        int n;
        int da;
        logic fd, ie;
        logic [31:0] tg;

        reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        irq_m = 1'b0;
        for (int i = 0; i < 4; i++) hash_m[i] = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        check("rst_enable", enable_switch, 1'b0);
        check("rst_drv_resetn", drv_resetn, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_rvalid", reg_rvalid, 1'b0);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_target_sel", target_selected, 128'd0);
        for (int a = 0; a < 9; a++) rd(4'(a), 32'd0, '1, 0, "rst_reg");
        rd(4'd13, 32'd0, '1, 0, "unmapped");

        // Random HASH traffic in IDLE, then the fixed pattern.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                hash_m[i] = $urandom();
                wr(4'(int'(ADDR_HASH0) + i), hash_m[i]);
            end
            for (int i = 0; i < 4; i++) rd(4'(int'(ADDR_HASH0) + i), hash_m[i], '1, 0, "hash_rand");
            check("target_sel_rand", target_selected, {hash_m[3], hash_m[2], hash_m[1], hash_m[0]});
        end
        rdwr(ADDR_HASH0, 32'h01234567, hash_m[0]);
        hash_m[0] = 32'h01234567;
        hash_m[1] = 32'h89ABCDEF; wr(ADDR_HASH1, hash_m[1]);
        hash_m[2] = 32'hFEDCBA98; wr(ADDR_HASH2, hash_m[2]);
        hash_m[3] = 32'h76543210; wr(ADDR_HASH3, hash_m[3]);
        for (int i = 0; i < 4; i++) rd(4'(int'(ADDR_HASH0) + i), hash_m[i], '1, 0, "hash_fixed");
        check("target_sel", target_selected, 128'h76543210FEDCBA9889ABCDEF01234567);
        wr(4'd12, 32'hDEADBEEF);
        rd(4'd12, 32'd0, '1, 0, "unmapped_wr");

        // Found search.
        start_search(200, 1'b1, 32'h00001000, 1'b0);
        finish_search(200, 1'b1, 32'h00001000, 1'b0);

        // Not-found search with interrupt, then IRQCLR.
        start_search(150, 1'b0, 32'hFFFFFFF8, 1'b1);
        finish_search(150, 1'b0, 32'hFFFFFFF8, 1'b1);
        wr(ADDR_IRQCLR, 32'd0);
        irq_m = 1'b0;
        @(negedge CLK);
        check("irqclr_irq", irq, 1'b0);
        rd(ADDR_STATUS, 32'h00, 32'hFF, 0, "irqclr_status");

        // Abort mid-search; HASH frozen while busy.
        start_search(1000, 1'b0, 32'd0, 1'b0);
        rd(ADDR_STATUS, 32'd2, 32'h07, 0, "status_search");
        wr(ADDR_HASH0, $urandom());
        rd(ADDR_HASH0, hash_m[0], '1, 0, "hash_frozen");
        check("target_sel_frozen", target_selected, {hash_m[3], hash_m[2], hash_m[1], hash_m[0]});
        wr(ADDR_CTRL, 32'h2);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!drv_resetn) n++;
            @(negedge CLK);
        end
        check("abort_resetn_cycles", 128'(n), 128'(ABORT_CYCLES));
        check("abort_enable", enable_switch, 1'b0);
        rd(ADDR_STATUS, 32'h80, 32'hFF, 0, "status_aborted");
        check("abort_irq", irq, 1'b0);

        // Start while searching is ignored; found result wraps below zero.
        start_search(60, 1'b1, 32'h00000100, 1'b0);
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_STATUS, 32'd2, 32'h07, 0, "start_in_search");
        finish_search(60, 1'b1, 32'h00000100, 1'b0);
        wr(ADDR_CTRL, 32'h3);
        rd(ADDR_STATUS, 32'h60, 32'hFF, 0, "start_abort_idle");
        check("start_abort_enable", enable_switch, 1'b0);

        // Randomized searches.
        for (int k = 0; k < 4; k++) begin
            da = $urandom_range(20, 80);
            fd = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            tg = ($urandom() & 32'hFFFFFFF8) | 32'($urandom_range(0, 3));
            start_search(da, fd, tg, ie);
            finish_search(da, fd, tg, ie);
            wr(ADDR_IRQCLR, 32'd1);
            irq_m = 1'b0;
            @(negedge CLK);
            check("rand_irqclr", irq, 1'b0);
            rd(ADDR_STATUS, {25'd0, fd, 6'd0}, 32'hFF, 0, "rand_status_clr");
        end

        // Leave irq set, start again, then reset mid-search.
        start_search(40, 1'b1, 32'h00005000, 1'b1);
        finish_search(40, 1'b1, 32'h00005000, 1'b1);
        start_search(1000, 1'b0, 32'd0, 1'b1);
        check("irq_held_in_search", irq, 1'b1);
        reset = 1'b1;
        @(negedge CLK);
        check("midrst_enable", enable_switch, 1'b0);
        check("midrst_irq", irq, 1'b0);
        check("midrst_drv_resetn", drv_resetn, 1'b1);
        check("midrst_rvalid", reg_rvalid, 1'b0);
        check("midrst_target_sel", target_selected, 128'd0);
        reset = 1'b0;
        irq_m = 1'b0;
        for (int a = 1; a < 8; a++) rd(4'(a), 32'd0, '1, 0, "midrst_reg");

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
